maze_neighbor_server: RTL

MAZE_NEIGHBOR_SERVER -- requirements
Module: maze_neighbor_server

---
 rtl/maze_neighbor_server.sv | 122 ++++++++++++
 1 files changed

// File: rtl/maze_neighbor_server.sv
// Maze neighbor server: answers one wall lookup at a time for a tile.
// Ports:
//   clk, reset_n             - clock, async active-low reset
//   req_valid/req_ready      - request handshake; req_pos = row*32+col
//   rom_addr/rom_data        - row address out, row word back one cycle later
//   resp_valid/resp_ready    - response handshake
//   resp_walls               - {right, left, down, up}, 1 = blocked
//   resp_pos                 - tile index the response belongs to
module maze_neighbor_server (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_pos,
    output logic [4:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [3:0]  resp_walls,
    output logic [9:0]  resp_pos
);

    typedef enum logic [2:0] {
        IDLE, RD_UP, RD_MID, RD_DN, CAP_DN, RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_pos;
    logic        r_up;
    logic        r_left;
    logic        r_right;
    logic [3:0]  r_walls;
    logic [9:0]  r_resp_pos;

    logic [4:0]  w_row;
    logic [4:0]  w_col;
    logic [4:0]  w_col_l;
    logic [4:0]  w_col_r;
    logic        w_dn;

    assign w_row   = r_pos[9:5];
    assign w_col   = r_pos[4:0];
    // 5-bit arithmetic gives the tunnel wrap for free
    assign w_col_l = w_col - 5'd1;
    assign w_col_r = w_col + 5'd1;
    assign w_dn    = (w_row == 5'd31) | rom_data[w_col];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rom_addr   = 5'd0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = RD_UP;
            end
            RD_UP: begin
                rom_addr = w_row - 5'd1;
                w_next   = RD_MID;
            end
            RD_MID: begin
                rom_addr = w_row;
                w_next   = RD_DN;
            end
            RD_DN: begin
                rom_addr = w_row + 5'd1;
                w_next   = CAP_DN;
            end
            CAP_DN: begin
                w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // rom_data in each state holds the row addressed one state earlier
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos      <= 10'd0;
            r_up       <= 1'b0;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_walls    <= 4'd0;
            r_resp_pos <= 10'd0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_pos <= req_pos;
            end
            if (r_state == RD_MID) begin
                r_up <= (w_row == 5'd0) | rom_data[w_col];
            end
            if (r_state == RD_DN) begin
                r_left  <= rom_data[w_col_l];
                r_right <= rom_data[w_col_r];
            end
            if (r_state == CAP_DN) begin
                r_walls    <= {r_right, r_left, w_dn, r_up};
                r_resp_pos <= r_pos;
            end
        end
    end

    assign resp_walls = r_walls;
    assign resp_pos   = r_resp_pos;

endmodule
